imm_extender: RTL and testbench
===============================

# imm_extender

Parametrised, handshaked immediate-extension unit for the CPU datapath. It widens an IN_W-bit immediate to OUT_W bits in one of four modes: zero, sign, high-place or ones-fill. Results are buffered in a small in-order output queue, so decode can run ahead of a stalled execute stage. It sits between instruction decode (producer) and the ALU operand mux (consumer).

## Interface
Parameters:
- IN_W, 16: immediate input width.
- OUT_W, 32: extended output width. OUT_W > IN_W is required; elaboration fails otherwise.
- DEPTH, 2: output queue entries, ≥1. Need not be a power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous queue clear (pipeline flush on branch or exception).
- in_valid  in  1  producer has an immediate.
- in_ready  out  1  unit can accept.
- in_data  in  IN_W  immediate.
- in_mode  in  2  extension mode (ext_mode_t).
- out_valid  out  1  queue head is valid.
- out_ready  in  1  consumer takes the head.
- out_data  out  OUT_W  extended value at the queue head.
- out_mode  out  2  mode the head was produced with (for debug and trace).

## Operation
Modes, computed combinationally on in_data at acceptance:
- 00 ZERO: upper OUT_W−IN_W bits are 0.
- 01 SIGN: upper bits are copies of in_data[IN_W−1].
- 10 HIGH: in_data occupies out[OUT_W−1 -: IN_W], remaining low bits 0 (LUI style).
- 11 ONES: upper OUT_W−IN_W bits are 1.

Handshake and queue:
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count != DEPTH) && !flush. It does not depend on out_ready, so there is no combinational ready path; a full queue does not accept even when a pop happens in the same cycle.
- out_valid = (count != 0). out_data and out_mode come from the storage entry at rd_ptr.
- Push alone: count+1. Pop alone: count−1. Push and pop together: count unchanged, both pointers advance.
- Pointers wrap from DEPTH−1 to 0 by explicit compare.
- flush: next edge sets count=0 and rd_ptr=wr_ptr=0. Flush beats any same-cycle push or pop; a push offered during flush is not accepted because in_ready is low.
- Order is strictly FIFO. No entry is dropped or duplicated.

Reset (asynchronous, while rst_n=0):
- count=0, pointers 0, all storage entries 0.
- out_valid=0, out_data=0, out_mode=0, in_ready=0.
- in_ready rises combinationally once rst_n=1.
- Reset asserted mid-operation discards all queued entries immediately, without waiting for a clock edge.

## Timing
- Latency: a push at edge t with the queue empty gives out_valid=1 and correct out_data in the cycle after t (one-cycle latency).
- Throughput: one transfer per cycle sustained when out_ready=1 and count<DEPTH.
- A full queue with a pop at edge t gives in_ready=1 in the cycle after t.
- After flush at edge t: out_valid=0 and in_ready=1 in the cycle after t (if flush has been deasserted).
- out_data and out_mode are stable while out_valid=1 and out_ready=0.

## Structure
- Package ext_pkg holds:
  - typedef ext_mode_t (EXT_ZERO=2'b00, EXT_SIGN, EXT_HIGH, EXT_ONES);
  - function ext_apply(data, mode), parametrised by widths through a local parameter or a wrapper.
- Sub-module ext_fifo: generic synchronous FIFO with parameters W and DEPTH, asynchronous active-low reset, and flush. It stores {mode, extended data}. imm_extender = ext_apply + ext_fifo + ready/valid glue.

## Test plan
Defaults IN_W=16, OUT_W=32, DEPTH=2 unless stated.
- Mode sweep: in_data=0x1234 in modes 0..3 → 0x00001234, 0x00001234, 0x12340000, 0xFFFF1234. Then 0x8001 SIGN → 0xFFFF8001; 0x8001 ZERO → 0x00008001.
- Backpressure: out_ready=0, offer 0x0001, 0x0002, 0x0003 → first two accepted, in_ready=0 after the second. Then out_ready=1 → outputs 0x00000001, 0x00000002 in order, then 0x0003 is accepted.
- Streaming: out_ready=1, 8 back-to-back pushes → 8 outputs on consecutive cycles, first one cycle after the first push; count never exceeds 1.
- Flush: two entries queued, flush=1 together with in_valid=1 → next cycle out_valid=0, and the offered word is never output.
- Async reset mid-run: two entries queued, rst_n driven low between edges → out_valid=0 and out_data=0 immediately. After release the queue is empty and in_ready=1.
- Odd params: IN_W=8, OUT_W=16, DEPTH=3, SIGN 0x80 → 0xFF80. Seven transfers under random out_ready → pointer wrap, with order and data preserved.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared types and the width-generic extension function for the immediate extender.
// ext_apply works on a fixed maximum width; callers pass their real widths as constants.
package ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_HIGH = 2'b10,
    EXT_ONES = 2'b11
  } ext_mode_t;

  localparam int unsigned ExtMaxW   = 64;
  localparam int unsigned ExtIdxW   = $clog2(ExtMaxW);

  // Bits at or above out_w are always returned as zero.
  function automatic logic [ExtMaxW-1:0] ext_apply(input logic [ExtMaxW-1:0] data,
                                                   input ext_mode_t          mode,
                                                   input int unsigned        in_w,
                                                   input int unsigned        out_w);
    logic [ExtMaxW-1:0] res;
    int unsigned        shift;
    res   = '0;
    shift = out_w - in_w;
    for (int unsigned i = 0; i < ExtMaxW; i++) begin
      if (i < out_w) begin
        if (mode == EXT_HIGH) begin
          if (i >= shift) res[ExtIdxW'(i)] = data[ExtIdxW'(i - shift)];
        end else if (i < in_w) begin
          res[ExtIdxW'(i)] = data[ExtIdxW'(i)];
        end else begin
          case (mode)
            EXT_SIGN: res[ExtIdxW'(i)] = data[ExtIdxW'(in_w - 1)];
            EXT_ONES: res[ExtIdxW'(i)] = 1'b1;
            default:  res[ExtIdxW'(i)] = 1'b0;
          endcase
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ext_fifo.sv
// Generic in-order FIFO with synchronous flush and asynchronous active-low reset.
// Depth need not be a power of two; pointers wrap by explicit compare.
module ext_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Ready is low during reset and never looks at the consumer side.
  assign push_ready_o = rst_ni && (count_q != FullCnt) && !flush_i;
  assign pop_valid_o  = (count_q != '0);
  assign pop_data_o   = mem_q[rd_ptr_q];

  assign push = push_valid_i && push_ready_o;
  assign pop  = pop_valid_o && pop_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/imm_extender.sv
// Handshaked immediate extender: extends on acceptance and queues {mode, value}
// so decode can run ahead of a stalled execute stage.
module imm_extender
  import ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  if (OUT_W <= IN_W) begin : g_bad_width
    $error("imm_extender: OUT_W must exceed IN_W");
  end
  if (OUT_W >= ExtMaxW) begin : g_too_wide
    $error("imm_extender: OUT_W must be below ExtMaxW");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("imm_extender: DEPTH must be at least 1");
  end

  logic [ExtMaxW-1:0] ext_full;
  logic [OUT_W+1:0]   push_word;
  logic [OUT_W+1:0]   head_word;
  logic               unused_ext;

  assign ext_full   = ext_apply(ExtMaxW'(in_data), ext_mode_t'(in_mode), IN_W, OUT_W);
  assign unused_ext = ^ext_full[ExtMaxW-1:OUT_W];
  assign push_word  = {in_mode, ext_full[OUT_W-1:0]};

  ext_fifo #(
    .W     (OUT_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  (push_word),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   (head_word)
  );

  assign out_data = head_word[OUT_W-1:0];
  assign out_mode = head_word[OUT_W+:2];

endmodule

// File: tb/tb_imm_extender.sv
// Directed self-checking bench for imm_extender: default build plus an
// IN_W=8 / OUT_W=16 / DEPTH=3 build sharing clock and reset.
module tb_imm_extender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  logic        o_flush = 1'b0;
  logic        o_in_valid = 1'b0;
  logic        o_in_ready;
  logic [7:0]  o_in_data = '0;
  logic [1:0]  o_in_mode = '0;
  logic        o_out_valid;
  logic        o_out_ready = 1'b0;
  logic [15:0] o_out_data;
  logic [1:0]  o_out_mode;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_extender dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  imm_extender #(
    .IN_W  (8),
    .OUT_W (16),
    .DEPTH (3)
  ) dut_odd (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (o_flush),
    .in_valid  (o_in_valid),
    .in_ready  (o_in_ready),
    .in_data   (o_in_data),
    .in_mode   (o_in_mode),
    .out_valid (o_out_valid),
    .out_ready (o_out_ready),
    .out_data  (o_out_data),
    .out_mode  (o_out_mode)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    tick();
    if (out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b want 0", out_valid); n_err++;
    end
    n_cmp++;
    if (out_data !== 32'h0 || out_mode !== 2'b00) begin
      $display("FAIL reset_out_data: got %h/%b want 0/0", out_data, out_mode); n_err++;
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready: got %b want 0", in_ready); n_err++;
    end
    n_cmp++;
    rst_n = 1'b1;
    #1;
    if (in_ready !== 1'b1 || o_in_ready !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b/%b want 1/1", in_ready, o_in_ready); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_modes;
    logic [15:0] vin  [6];
    logic [1:0]  vm   [6];
    logic [31:0] vexp [6];
    vin[0] = 16'h1234; vm[0] = 2'b00; vexp[0] = 32'h00001234;
    vin[1] = 16'h1234; vm[1] = 2'b01; vexp[1] = 32'h00001234;
    vin[2] = 16'h1234; vm[2] = 2'b10; vexp[2] = 32'h12340000;
    vin[3] = 16'h1234; vm[3] = 2'b11; vexp[3] = 32'hFFFF1234;
    vin[4] = 16'h8001; vm[4] = 2'b01; vexp[4] = 32'hFFFF8001;
    vin[5] = 16'h8001; vm[5] = 2'b00; vexp[5] = 32'h00008001;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = vin[i];
      in_mode  = vm[i];
      tick();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_data !== vexp[i] || out_mode !== vm[i]) begin
        $display("FAIL mode_%0d: got v=%b %h/%b want 1 %h/%b", i, out_valid, out_data,
                 out_mode, vexp[i], vm[i]);
        n_err++;
      end
      n_cmp++;
      tick();
    end
    if (out_valid !== 1'b0) begin
      $display("FAIL modes_drained: got %b want 0", out_valid); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = 16'h0001;
    tick();
    in_data = 16'h0002;
    tick();
    in_data = 16'h0003;
    if (in_ready !== 1'b0) begin
      $display("FAIL bp_full_ready: got %b want 0", in_ready); n_err++;
    end
    n_cmp++;
    tick();
    if (out_data !== 32'h1 || out_valid !== 1'b1) begin
      $display("FAIL bp_hold_head: got %b %h want 1 00000001", out_valid, out_data); n_err++;
    end
    n_cmp++;
    out_ready = 1'b1;
    #1;
    if (in_ready !== 1'b0) begin
      $display("FAIL bp_no_comb_ready: got %b want 0", in_ready); n_err++;
    end
    n_cmp++;
    tick();
    if (out_data !== 32'h2 || in_ready !== 1'b1) begin
      $display("FAIL bp_second: got %h rdy %b want 00000002 rdy 1", out_data, in_ready); n_err++;
    end
    n_cmp++;
    tick();
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || out_data !== 32'h3) begin
      $display("FAIL bp_third: got %b %h want 1 00000003", out_valid, out_data); n_err++;
    end
    n_cmp++;
    tick();
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_drained: got %b want 0", out_valid); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_streaming;
    logic [31:0] exp_v;
    logic        ok;
    ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_mode  = 2'b01;
      in_data  = 16'hFFF0 + 16'(i);
      tick();
      exp_v = 32'hFFFFFFF0 + 32'(i);
      if (out_valid !== 1'b1 || out_data !== exp_v || in_ready !== 1'b1) begin
        $display("FAIL stream_%0d: got v=%b %h rdy %b want 1 %h rdy 1", i, out_valid,
                 out_data, in_ready, exp_v);
        ok = 1'b0;
      end
    end
    if (!ok) n_err++;
    n_cmp++;
    in_valid = 1'b0;
    tick();
    if (out_valid !== 1'b0) begin
      $display("FAIL stream_drained: got %b want 0", out_valid); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_flush;
    logic seen;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = 16'hAAAA;
    tick();
    in_data = 16'hBBBB;
    tick();
    flush   = 1'b1;
    in_data = 16'h00EE;
    #1;
    if (in_ready !== 1'b0) begin
      $display("FAIL flush_ready_low: got %b want 0", in_ready); n_err++;
    end
    n_cmp++;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_cleared: got v=%b rdy=%b want 0 1", out_valid, in_ready); n_err++;
    end
    n_cmp++;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    if (seen !== 1'b0) begin
      $display("FAIL flush_no_output: got %b want 0", seen); n_err++;
    end
    n_cmp++;
    in_valid = 1'b1;
    in_data  = 16'h0042;
    tick();
    in_valid = 1'b0;
    if (out_valid !== 1'b1 || out_data !== 32'h42) begin
      $display("FAIL flush_after_push: got %b %h want 1 00000042", out_valid, out_data); n_err++;
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b11;
    in_data   = 16'h5555;
    tick();
    in_data = 16'h6666;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_mode !== 2'b00) begin
      $display("FAIL arst_immediate: got %b %h/%b want 0 0/0", out_valid, out_data, out_mode);
      n_err++;
    end
    n_cmp++;
    #1;
    rst_n = 1'b1;
    #1;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL arst_release: got v=%b rdy=%b want 0 1", out_valid, in_ready); n_err++;
    end
    n_cmp++;
    tick();
    if (out_valid !== 1'b0) begin
      $display("FAIL arst_empty: got %b want 0", out_valid); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_odd_params;
    logic [7:0]  din  [7];
    logic [1:0]  dm   [7];
    logic [15:0] dexp [7];
    int          sent, recv, cyc;
    logic        acc, popped;
    din[0] = 8'h11; dm[0] = 2'b00; dexp[0] = 16'h0011;
    din[1] = 8'h92; dm[1] = 2'b01; dexp[1] = 16'hFF92;
    din[2] = 8'h23; dm[2] = 2'b10; dexp[2] = 16'h2300;
    din[3] = 8'h34; dm[3] = 2'b11; dexp[3] = 16'hFF34;
    din[4] = 8'hC5; dm[4] = 2'b00; dexp[4] = 16'h00C5;
    din[5] = 8'h56; dm[5] = 2'b01; dexp[5] = 16'h0056;
    din[6] = 8'hA7; dm[6] = 2'b10; dexp[6] = 16'hA700;
    o_out_ready = 1'b1;
    o_in_valid  = 1'b1;
    o_in_data   = 8'h80;
    o_in_mode   = 2'b01;
    tick();
    o_in_valid = 1'b0;
    if (o_out_valid !== 1'b1 || o_out_data !== 16'hFF80) begin
      $display("FAIL odd_sign: got %b %h want 1 ff80", o_out_valid, o_out_data); n_err++;
    end
    n_cmp++;
    tick();
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 7 && cyc < 200) begin
      o_in_valid  = (sent < 7);
      o_in_data   = din[(sent < 7) ? sent : 6];
      o_in_mode   = dm[(sent < 7) ? sent : 6];
      o_out_ready = 1'($urandom_range(0, 1));
      #1;
      acc    = o_in_valid && o_in_ready;
      popped = o_out_valid && o_out_ready;
      if (popped) begin
        if (o_out_data !== dexp[recv] || o_out_mode !== dm[recv]) begin
          $display("FAIL odd_order_%0d: got %h/%b want %h/%b", recv, o_out_data, o_out_mode,
                   dexp[recv], dm[recv]);
          n_err++;
        end
        n_cmp++;
        recv++;
      end
      if (acc) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    o_in_valid = 1'b0;
    if (recv != 7) begin
      $display("FAIL odd_timeout: got %0d outputs want 7", recv); n_err++;
    end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_flush();
    test_async_reset();
    test_odd_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
